fire_expand3_ofm_writer: RTL and testbench

- Receiving end of a fire expand 3x3 layer's output interface.
- On each sample pulse, captures the DSP_NO parallel ReLU'd outputs of one pixel and serializes them into the output feature-map RAM in channel-major order.
- Tracks pixel count across the whole layer; once all writes have retired and the layer reports finish, returns the one-cycle ram_feedback pulse the layer uses to drop its finish flag.
- Sits between the fire4/fire5 expand 3x3 core and the ofm BRAM feeding the next layer.

---
 rtl/fire_pkg.sv | 18 +
 rtl/fire_expand3_ofm_writer_addr_gen.sv | 45 ++++
 rtl/fire_expand3_ofm_writer.sv | 124 ++++++++++++
 tb/tb_fire_expand3_ofm_writer.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fire_pkg.sv
// Shared constants and types for the fire expand 3x3 output path.
// Default geometry matches the fire4/fire5 expand 3x3 layers.
package fire_pkg;

    localparam int WIDTH         = 16;
    localparam int DSP_NO        = 128;
    localparam int WOUT          = 32;
    localparam int PIX_PER_LAYER = WOUT * WOUT;

    typedef logic [WIDTH-1:0] ofm_vec_t [0:DSP_NO-1];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/fire_expand3_ofm_writer_addr_gen.sv
// Channel/pixel counters and channel-major ofm RAM address.
// ch/pix always name the next word to be written.
module ofm_addr_gen #(
    parameter int DSP_NO    = fire_pkg::DSP_NO,
    parameter int WOUT      = fire_pkg::WOUT,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 17,
    parameter int CH_W      = (DSP_NO > 1) ? $clog2(DSP_NO) : 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              inc_ch,
    output logic              last_ch,
    output logic              last_pix,
    output logic [CH_W-1:0]   ch,
    output logic [ADDR_W-1:0] addr
);

    localparam int PIX   = WOUT * WOUT;
    localparam int PIX_W = $clog2(PIX + 1);

    logic [PIX_W-1:0] pix;

    always_ff @(posedge clk) begin
        if (clear) begin
            ch  <= '0;
            pix <= '0;
        end else if (inc_ch) begin
            if (last_ch) begin
                ch  <= '0;
                pix <= pix + PIX_W'(1);
            end else begin
                ch <= ch + CH_W'(1);
            end
        end
    end

    assign last_ch  = (ch == CH_W'(DSP_NO - 1));
    assign last_pix = (pix == PIX_W'(PIX - 1));

    assign addr = ADDR_W'(BASE_ADDR)
                + ADDR_W'(ch) * ADDR_W'(PIX)
                + ADDR_W'(pix);

endmodule

// File: rtl/fire_expand3_ofm_writer.sv
// Captures one pixel of expand 3x3 outputs per sample and serializes it
// into the ofm RAM, then hands the layer its one-shot completion pulse.
module fire_expand3_ofm_writer
    import fire_pkg::*;
#(
    parameter int WIDTH     = fire_pkg::WIDTH,
    parameter int DSP_NO    = fire_pkg::DSP_NO,
    parameter int WOUT      = fire_pkg::WOUT,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_i,
    input  logic [WIDTH-1:0]  ofm_i [0:DSP_NO-1],
    input  logic              layer_finish_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [WIDTH-1:0]  wr_data_o,
    output logic              ram_feedback_o,
    output logic              busy_o,
    output logic              overflow_o
);

    localparam int CH_W = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

    wr_state_e state;

    logic [WIDTH-1:0]  buffer [0:DSP_NO-1];
    logic [CH_W-1:0]   ch;
    logic [ADDR_W-1:0] addr;
    logic              last_ch;
    logic              last_pix;
    logic              last_wr;
    logic              last_wr_pix;
    logic              feedback_sent;
    logic              cap;
    logic              drn;
    logic              inc_ch;

    ofm_addr_gen #(
        .DSP_NO    (DSP_NO),
        .WOUT      (WOUT),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_W    (ADDR_W),
        .CH_W      (CH_W)
    ) u_addr_gen (
        .clk      (clk),
        .clear    (rst),
        .inc_ch   (inc_ch),
        .last_ch  (last_ch),
        .last_pix (last_pix),
        .ch       (ch),
        .addr     (addr)
    );

    // Channel 0 leaves straight from ofm_i on the capture edge, so a
    // sample landing on the last drain write chains with no bubble.
    always_comb begin
        cap = 1'b0;
        drn = 1'b0;
        case (state)
            IDLE:    cap = sample_i;
            DRAIN: begin
                if (!last_wr)
                    drn = 1'b1;
                else if (!last_wr_pix)
                    cap = sample_i;
            end
            default: ;
        endcase
        inc_ch = cap | drn;
    end

    always_ff @(posedge clk) begin
        if (cap)
            buffer <= ofm_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wr_en_o        <= 1'b0;
            wr_addr_o      <= '0;
            wr_data_o      <= '0;
            last_wr        <= 1'b0;
            last_wr_pix    <= 1'b0;
            feedback_sent  <= 1'b0;
            ram_feedback_o <= 1'b0;
            overflow_o     <= 1'b0;
        end else begin
            wr_en_o        <= inc_ch;
            last_wr        <= inc_ch && last_ch;
            last_wr_pix    <= inc_ch && last_ch && last_pix;
            ram_feedback_o <= 1'b0;
            if (inc_ch) begin
                wr_addr_o <= addr;
                wr_data_o <= cap ? ofm_i[0] : buffer[ch];
            end
            if (sample_i && !cap)
                overflow_o <= 1'b1;
            case (state)
                IDLE: begin
                    if (cap)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (last_wr && !cap)
                        state <= last_wr_pix ? DONE : IDLE;
                end
                DONE: begin
                    if (layer_finish_i && !feedback_sent) begin
                        ram_feedback_o <= 1'b1;
                        feedback_sent  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o = (state == DRAIN);

endmodule

// File: tb/tb_fire_expand3_ofm_writer.sv
// Directed bench: full-size writer, offset-base writer and a small
// 4-channel 4x4 writer sharing one clock and reset.
module tb_fire_expand3_ofm_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic        a_sample = 1'b0;
    logic [15:0] a_ofm [0:127];
    logic        a_fin = 1'b0;
    logic        a_en;
    logic [16:0] a_addr;
    logic [15:0] a_data;
    logic        a_fb;
    logic        a_busy;
    logic        a_ovf;

    logic        b_sample = 1'b0;
    logic [15:0] b_ofm [0:127];
    logic        b_fin = 1'b0;
    logic        b_en;
    logic [17:0] b_addr;
    logic [15:0] b_data;
    logic        b_fb;
    logic        b_busy;
    logic        b_ovf;

    logic        c_sample = 1'b0;
    logic [15:0] c_ofm [0:3];
    logic        c_fin = 1'b0;
    logic        c_en;
    logic [6:0]  c_addr;
    logic [15:0] c_data;
    logic        c_fb;
    logic        c_busy;
    logic        c_ovf;

    int total = 0;
    int bad = 0;

    fire_expand3_ofm_writer dut_a (
        .clk            (clk),
        .rst            (rst),
        .sample_i       (a_sample),
        .ofm_i          (a_ofm),
        .layer_finish_i (a_fin),
        .wr_en_o        (a_en),
        .wr_addr_o      (a_addr),
        .wr_data_o      (a_data),
        .ram_feedback_o (a_fb),
        .busy_o         (a_busy),
        .overflow_o     (a_ovf)
    );

    fire_expand3_ofm_writer #(
        .BASE_ADDR (4096),
        .ADDR_W    (18)
    ) dut_b (
        .clk            (clk),
        .rst            (rst),
        .sample_i       (b_sample),
        .ofm_i          (b_ofm),
        .layer_finish_i (b_fin),
        .wr_en_o        (b_en),
        .wr_addr_o      (b_addr),
        .wr_data_o      (b_data),
        .ram_feedback_o (b_fb),
        .busy_o         (b_busy),
        .overflow_o     (b_ovf)
    );

    fire_expand3_ofm_writer #(
        .DSP_NO (4),
        .WOUT   (4),
        .ADDR_W (7)
    ) dut_c (
        .clk            (clk),
        .rst            (rst),
        .sample_i       (c_sample),
        .ofm_i          (c_ofm),
        .layer_finish_i (c_fin),
        .wr_en_o        (c_en),
        .wr_addr_o      (c_addr),
        .wr_data_o      (c_data),
        .ram_feedback_o (c_fb),
        .busy_o         (c_busy),
        .overflow_o     (c_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_sample = 1'b0;
        b_sample = 1'b0;
        c_sample = 1'b0;
        a_fin = 1'b0;
        b_fin = 1'b0;
        c_fin = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({a_en, a_fb, a_busy, a_ovf} !== 4'b0 || a_addr !== 17'd0
            || a_data !== 16'd0) begin
            bad++;
            $display("FAIL reset_a en=%b fb=%b busy=%b ovf=%b addr=%0d data=%0d want all 0",
                     a_en, a_fb, a_busy, a_ovf, a_addr, a_data);
        end
        total++;
        if ({b_en, b_fb, b_busy, b_ovf, c_en, c_fb, c_busy, c_ovf} !== 8'b0) begin
            bad++;
            $display("FAIL reset_bc flags=%b want 00000000",
                     {b_en, b_fb, b_busy, b_ovf, c_en, c_fb, c_busy, c_ovf});
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int k = 0; k < 128; k++) a_ofm[k] = 16'(k + 1);
        a_sample = 1'b1;
        step();
        a_sample = 1'b0;
        for (int k = 0; k < 128; k++) begin
            total++;
            if (a_en !== 1'b1 || a_busy !== 1'b1 || a_addr !== 17'(k * 1024)
                || a_data !== 16'(k + 1)) begin
                bad++;
                $display("FAIL single k=%0d got en=%b busy=%b addr=%0d data=%0d want 1 1 %0d %0d",
                         k, a_en, a_busy, a_addr, a_data, k * 1024, k + 1);
            end
            step();
        end
        total++;
        if (a_en !== 1'b0 || a_busy !== 1'b0 || a_ovf !== 1'b0) begin
            bad++;
            $display("FAIL single_end got en=%b busy=%b ovf=%b want 0 0 0",
                     a_en, a_busy, a_ovf);
        end
    endtask

    task automatic test_overflow();
        int nw;
        do_reset();
        nw = 0;
        for (int k = 0; k < 128; k++) a_ofm[k] = 16'h4000 + 16'(k);
        a_sample = 1'b1;
        step();
        a_sample = 1'b0;
        for (int i = 0; i < 140; i++) begin
            total++;
            if (i < 128) begin
                if (a_en !== 1'b1 || a_addr !== 17'(i * 1024)
                    || a_data !== 16'h4000 + 16'(i)) begin
                    bad++;
                    $display("FAIL ovf_write i=%0d got en=%b addr=%0d data=%h want 1 %0d %h",
                             i, a_en, a_addr, a_data, i * 1024, 16'h4000 + 16'(i));
                end
            end else if (a_en !== 1'b0) begin
                bad++;
                $display("FAIL ovf_extra i=%0d got en=%b want 0", i, a_en);
            end
            if (a_en === 1'b1) nw++;
            a_sample = (i == 49);
            step();
        end
        total++;
        if (nw !== 128 || a_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_flag got writes=%0d ovf=%b want 128 1", nw, a_ovf);
        end
        a_sample = 1'b1;
        step();
        a_sample = 1'b0;
        total++;
        if (a_en !== 1'b1 || a_addr !== 17'd1 || a_data !== 16'h4000) begin
            bad++;
            $display("FAIL ovf_next_pix got en=%b addr=%0d data=%h want 1 1 4000",
                     a_en, a_addr, a_data);
        end
        repeat (130) step();
        total++;
        if (a_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky got ovf=%b want 1", a_ovf);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 128; k++) a_ofm[k] = 16'(k + 1);
        a_sample = 1'b1;
        step();
        a_sample = 1'b0;
        for (int i = 0; i < 256; i++) begin
            total++;
            if (a_en !== 1'b1 || a_busy !== 1'b1
                || a_addr !== 17'((i % 128) * 1024 + i / 128)
                || a_data !== (i < 128 ? 16'(i + 1) : 16'h8000 + 16'(i - 128))) begin
                bad++;
                $display("FAIL b2b i=%0d got en=%b busy=%b addr=%0d data=%h want 1 1 %0d",
                         i, a_en, a_busy, a_addr, a_data, (i % 128) * 1024 + i / 128);
            end
            if (i == 127) begin
                a_sample = 1'b1;
                for (int k = 0; k < 128; k++) a_ofm[k] = 16'h8000 + 16'(k);
            end else begin
                a_sample = 1'b0;
            end
            step();
        end
        total++;
        if (a_en !== 1'b0 || a_busy !== 1'b0 || a_ovf !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end got en=%b busy=%b ovf=%b want 0 0 0",
                     a_en, a_busy, a_ovf);
        end
    endtask

    task automatic test_base_addr();
        do_reset();
        for (int k = 0; k < 128; k++) b_ofm[k] = 16'h1000 + 16'(k);
        b_sample = 1'b1;
        step();
        b_sample = 1'b0;
        for (int k = 0; k < 128; k++) begin
            total++;
            if (b_en !== 1'b1 || b_addr !== 18'(4096 + k * 1024)
                || b_data !== 16'h1000 + 16'(k)) begin
                bad++;
                $display("FAIL base k=%0d got en=%b addr=%0d data=%h want 1 %0d %h",
                         k, b_en, b_addr, b_data, 4096 + k * 1024, 16'h1000 + 16'(k));
            end
            step();
        end
        total++;
        if (b_en !== 1'b0 || b_ovf !== 1'b0) begin
            bad++;
            $display("FAIL base_end got en=%b ovf=%b want 0 0", b_en, b_ovf);
        end
    endtask

    task automatic test_full_layer();
        int fb_cnt;
        do_reset();
        for (int p = 0; p < 16; p++) begin
            for (int k = 0; k < 4; k++) c_ofm[k] = 16'(p * 16 + k);
            c_sample = 1'b1;
            step();
            c_sample = 1'b0;
            for (int j = 0; j < 10; j++) begin
                total++;
                if (j < 4) begin
                    if (c_en !== 1'b1 || c_addr !== 7'(j * 16 + p)
                        || c_data !== 16'(p * 16 + j)) begin
                        bad++;
                        $display("FAIL layer p=%0d ch=%0d got en=%b addr=%0d data=%0d want 1 %0d %0d",
                                 p, j, c_en, c_addr, c_data, j * 16 + p, p * 16 + j);
                    end
                end else if (c_en !== 1'b0 || c_fb !== 1'b0) begin
                    bad++;
                    $display("FAIL layer_gap p=%0d j=%0d got en=%b fb=%b want 0 0",
                             p, j, c_en, c_fb);
                end
                step();
            end
        end
        total++;
        if (c_busy !== 1'b0 || c_fb !== 1'b0 || c_ovf !== 1'b0) begin
            bad++;
            $display("FAIL layer_done got busy=%b fb=%b ovf=%b want 0 0 0",
                     c_busy, c_fb, c_ovf);
        end
        c_fin = 1'b1;
        fb_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (c_fb === 1'b1) fb_cnt++;
        end
        total++;
        if (fb_cnt !== 1) begin
            bad++;
            $display("FAIL layer_feedback got pulses=%0d want 1", fb_cnt);
        end
        c_sample = 1'b1;
        step();
        c_sample = 1'b0;
        step();
        total++;
        if (c_ovf !== 1'b1 || c_en !== 1'b0 || c_fb !== 1'b0) begin
            bad++;
            $display("FAIL done_sample got ovf=%b en=%b fb=%b want 1 0 0",
                     c_ovf, c_en, c_fb);
        end
    endtask

    task automatic test_reset_mid();
        logic fb_seen;
        do_reset();
        fb_seen = 1'b0;
        a_fin = 1'b1;
        for (int k = 0; k < 128; k++) a_ofm[k] = 16'h2000 + 16'(k);
        for (int p = 0; p < 6; p++) begin
            a_sample = 1'b1;
            step();
            a_sample = 1'b0;
            if (p < 5) begin
                for (int i = 0; i < 130; i++) begin
                    fb_seen |= a_fb;
                    step();
                end
            end
        end
        repeat (60) step();
        total++;
        if (a_en !== 1'b1 || a_addr !== 17'(60 * 1024 + 5)) begin
            bad++;
            $display("FAIL mid_pos got en=%b addr=%0d want 1 %0d",
                     a_en, a_addr, 60 * 1024 + 5);
        end
        rst = 1'b1;
        step();
        total++;
        if (a_en !== 1'b0 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_abort got en=%b busy=%b want 0 0", a_en, a_busy);
        end
        rst = 1'b0;
        a_sample = 1'b1;
        step();
        a_sample = 1'b0;
        for (int k = 0; k < 128; k++) begin
            total++;
            if (a_en !== 1'b1 || a_addr !== 17'(k * 1024)
                || a_data !== 16'h2000 + 16'(k)) begin
                bad++;
                $display("FAIL mid_restart k=%0d got en=%b addr=%0d data=%h want 1 %0d %h",
                         k, a_en, a_addr, a_data, k * 1024, 16'h2000 + 16'(k));
            end
            fb_seen |= a_fb;
            step();
        end
        total++;
        if (fb_seen !== 1'b0 || a_fb !== 1'b0) begin
            bad++;
            $display("FAIL early_finish got feedback=%b want 0", fb_seen | a_fb);
        end
    endtask

    initial begin
        for (int k = 0; k < 128; k++) begin
            a_ofm[k] = '0;
            b_ofm[k] = '0;
        end
        for (int k = 0; k < 4; k++) c_ofm[k] = '0;
        test_reset();
        test_single();
        test_overflow();
        test_back_to_back();
        test_base_addr();
        test_full_layer();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
